event_window_counter: RTL
=========================

# event_window_counter

Counts single-cycle detection pulses from the run-of-ones detector FSM over a fixed window of clock cycles. It sits directly downstream of that detector, taking its `q` output on `ev_in`. At the end of each window it publishes the pulse count through a one-deep valid/ready output register, and it flags lost results.

## Interface
Parameters:
- `CNT_W`, default 8: width of the count and of `cnt_data`.
- `WIN_LEN`, default 16: window length in clock cycles; must be ≥ 2.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `arstn`, in, 1: reset, asynchronous and active-low.
- `ev_in`, in, 1: detector pulse; sampled every cycle.
- `win_en`, in, 1: window enable; level-sensitive.
- `cnt_data`, out, `CNT_W`: count of the last completed window.
- `cnt_valid`, out, 1: `cnt_data` holds an unconsumed result.
- `cnt_ready`, in, 1: consumer accepts when `cnt_valid && cnt_ready` at an edge.
- `ovf`, out, 1: sticky flag; an unconsumed result was overwritten.

## Operation
- The FSM has two states, IDLE and RUN. Reset state is IDLE.
- IDLE:
  - Timer = 0 and accumulator = 0; `ev_in` is ignored.
  - If `win_en` = 1 at an edge, go to RUN.
- RUN, each edge:
  - Accumulator += `ev_in`; timer += 1.
  - At the edge where timer == `WIN_LEN`−1 (last window cycle), load accumulator + `ev_in` into `cnt_data` and set `cnt_valid`. Clear the accumulator and timer.
  - After that edge, stay in RUN if `win_en` = 1, otherwise go to IDLE. Consecutive windows have no gap cycle.
- `win_en` = 0 at any RUN edge other than the last window cycle: the partial window is discarded. Accumulator and timer clear, the state returns to IDLE, and no load occurs.
- Output register:
  - `cnt_valid` clears on handshake when no load happens in the same cycle.
  - Load and handshake in the same cycle: the old value is consumed, the new value is loaded, `cnt_valid` stays 1, and `ovf` is unchanged.
  - Load while `cnt_valid` = 1 and `cnt_ready` = 0: the new value overwrites the old, `cnt_valid` stays 1, and `ovf` is set to 1.
  - `ovf` clears only on reset.
- Arithmetic:
  - The accumulator is `CNT_W` bits.
  - The timer is $clog2(`WIN_LEN`) bits.
  - Overflow of the accumulator is handled per Configuration.
- `cnt_data` is stable while `cnt_valid` = 1 until a handshake or an overwrite.

## Timing
- Reset values: `cnt_data` = 0, `cnt_valid` = 0, `ovf` = 0, state IDLE, timer = 0, accumulator = 0.
  - Applied immediately on `arstn` falling, without waiting for a clock edge.
  - Also applies when reset is asserted mid-window or with a pending result: all are lost.
- Latency:
  - Edge E0 samples `win_en` = 1 in IDLE.
  - Window cycles are sampled at edges E1..E`WIN_LEN`.
  - `cnt_valid` is visible after edge E`WIN_LEN`.
- An `ev_in` pulse on the final window cycle is counted in the current window, not the next.
- Throughput: one result per `WIN_LEN` cycles. There is no backpressure on counting; results that are not accepted are overwritten.

## Configuration
- Macro `EVCNT_SAT_EN`.
- Defined: the accumulator saturates at 2^`CNT_W`−1 and further pulses are ignored; `cnt_data` reports all-ones.
- Undefined: the accumulator wraps modulo 2^`CNT_W`.
- Ports and timing are identical in both builds.

## Structure
- Package `event_window_pkg`:
  - State enum typedef (`IDLE`, `RUN`).
  - State-encoding localparams.
- Sub-module `evcnt_out_reg`:
  - One-deep valid/ready holding register.
  - Inputs: `load`, `load_data`, `cnt_ready`.
  - Outputs: `cnt_data`, `cnt_valid`, `ovf`.
  - The top level holds the FSM, timer and accumulator.

## Test plan
All scenarios use `CNT_W` = 8 and `WIN_LEN` = 16 unless stated.
- Reset: hold `arstn` = 0 with random inputs → `cnt_data` = 0, `cnt_valid` = 0, `ovf` = 0. Deassert with `win_en` = 0 → outputs stay 0.
- Basic window: `win_en` = 1, `cnt_ready` = 1, `ev_in` high on window cycles 3, 6, 9, 12 and 16 → `cnt_valid` high for exactly one cycle after E16, `cnt_data` = 5, `ovf` = 0.
- Overwrite: `cnt_ready` = 0 across two back-to-back windows with 3 then 7 events → after the second window `cnt_data` = 7, `cnt_valid` = 1, `ovf` = 1. Raise `cnt_ready` → `cnt_valid` drops and `ovf` stays 1.
- Abort: drop `win_en` at window cycle 8 after 4 events → no `cnt_valid`. Re-enable with 2 events in a full window → `cnt_data` = 2.
- Width limit: `CNT_W` = 3, `ev_in` held at 1 for a full window → `cnt_data` = 0 without `EVCNT_SAT_EN`, 7 with it.
- Simultaneous load and accept: a result is pending and `cnt_ready` = 1 on the final cycle of the next window → new count is loaded, `cnt_valid` stays 1, `ovf` = 0. Also pull `arstn` low mid-window → all outputs 0 immediately.

Source files
------------

// File: rtl/event_window_pkg.sv
`default_nettype none
// ============================================================================
// Module      : event_window_pkg
// Description : Shared state type and state encodings for the event window
//               counter. The FSM has two states: IDLE (no window open) and
//               RUN (a window is being timed and pulses are accumulated).
// Macros      : none (EVCNT_SAT_EN is consumed by event_window_counter)
// Revision    : 1.0 - initial release
// ============================================================================
package event_window_pkg;

  // Explicit encodings kept as 1-bit constants so that older flows can
  // reference the raw state values directly.
  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_RUN  = 1'b1;

  typedef enum logic [0:0] {
    IDLE = c_ST_IDLE,
    RUN  = c_ST_RUN
  } state_e;

endpackage : event_window_pkg
`default_nettype wire

// File: rtl/evcnt_out_reg.sv
`default_nettype none
// ============================================================================
// Module      : evcnt_out_reg
// Description : One-deep valid/ready holding register for window counts.
//               A load always wins; if it replaces a result the consumer has
//               not taken in the same cycle, the sticky ovf flag is raised.
// Ports       : clk, arstn        - clock, async active-low reset
//               load, load_data   - new window result strobe and value
//               cnt_ready         - consumer accept
//               cnt_data          - held result
//               cnt_valid         - held result not yet consumed
//               ovf               - sticky: an unconsumed result was lost
// Revision    : 1.0 - initial release
// ============================================================================
module evcnt_out_reg #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             load,
  input  logic [CNT_W-1:0] load_data,
  input  logic             cnt_ready,
  output logic [CNT_W-1:0] cnt_data,
  output logic             cnt_valid,
  output logic             ovf
);

  logic [CNT_W-1:0] r_data;
  logic             r_valid;
  logic             r_ovf;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (load) begin
      r_data  <= load_data;
      r_valid <= 1'b1;
      // Loss only when the old result is still pending and not being
      // accepted on this same edge.
      if (r_valid && !cnt_ready) begin
        r_ovf <= 1'b1;
      end
    end else if (r_valid && cnt_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign cnt_data  = r_data;
  assign cnt_valid = r_valid;
  assign ovf       = r_ovf;

endmodule : evcnt_out_reg
`default_nettype wire

// File: rtl/event_window_counter.sv
`default_nettype none
// ============================================================================
// Module      : event_window_counter
// Description : Counts single-cycle detector pulses over windows of WIN_LEN
//               clock cycles and publishes each window's count through a
//               one-deep valid/ready output register.
// Macros      : EVCNT_SAT_EN - when defined the accumulator saturates at
//               all-ones; otherwise it wraps modulo 2^CNT_W.
// Ports       : clk, arstn  - clock, async active-low reset
//               ev_in       - detector pulse, sampled every cycle
//               win_en      - window enable (level)
//               cnt_data    - count of the last completed window
//               cnt_valid   - cnt_data holds an unconsumed result
//               cnt_ready   - consumer accept
//               ovf         - sticky overwrite flag
// Revision    : 1.0 - initial release
// ============================================================================
module event_window_counter
  import event_window_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int WIN_LEN = 16
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             ev_in,
  input  logic             win_en,
  output logic [CNT_W-1:0] cnt_data,
  output logic             cnt_valid,
  input  logic             cnt_ready,
  output logic             ovf
);

  localparam int                   c_TIMER_W = $clog2(WIN_LEN);
  localparam logic [c_TIMER_W-1:0] c_LAST    = c_TIMER_W'(WIN_LEN - 1);
  localparam logic [c_TIMER_W-1:0] c_ONE     = c_TIMER_W'(1);

  state_e               r_state;
  logic [c_TIMER_W-1:0] r_timer;
  logic [CNT_W-1:0]     r_acc;

  logic                 w_last;
  logic [CNT_W-1:0]     w_sum;

  assign w_last = (r_state == RUN) && (r_timer == c_LAST);

`ifdef EVCNT_SAT_EN
  // Hold at all-ones once reached; further pulses are dropped.
  assign w_sum = (&r_acc) ? r_acc : (r_acc + CNT_W'(ev_in));
`else
  assign w_sum = r_acc + CNT_W'(ev_in);
`endif

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_acc   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_timer <= '0;
          r_acc   <= '0;
          if (win_en) begin
            r_state <= RUN;
          end
        end
        RUN: begin
          // Window end (result handed to the output register) and abort
          // both restart from zero; only win_en decides whether the next
          // window follows without a gap.
          if (w_last || !win_en) begin
            r_timer <= '0;
            r_acc   <= '0;
            r_state <= win_en ? RUN : IDLE;
          end else begin
            r_timer <= r_timer + c_ONE;
            r_acc   <= w_sum;
          end
        end
        default: begin
          r_state <= IDLE;
          r_timer <= '0;
          r_acc   <= '0;
        end
      endcase
    end
  end

  // The pulse on the final window cycle is folded in through w_sum.
  evcnt_out_reg #(
    .CNT_W (CNT_W)
  ) u_out_reg (
    .clk       (clk),
    .arstn     (arstn),
    .load      (w_last),
    .load_data (w_sum),
    .cnt_ready (cnt_ready),
    .cnt_data  (cnt_data),
    .cnt_valid (cnt_valid),
    .ovf       (ovf)
  );

endmodule : event_window_counter
`default_nettype wire
